// File: rtl/contador_pkg.sv
// Shared definitions for the multi-channel cycle/event counter.
// Combinational only: constants, no latency.
// No flow control: pure definitions.
package contador_pkg;

  // Width of the run/halt FSM state register.
  localparam int NB_ESTADO = 2;

  // FSM encodings; these values are visible on o_estado.
  localparam logic [NB_ESTADO-1:0] ESTADO_IDLE   = 2'b00;
  localparam logic [NB_ESTADO-1:0] ESTADO_RUN    = 2'b01;
  localparam logic [NB_ESTADO-1:0] ESTADO_HALTED = 2'b10;

endpackage

// File: rtl/contador_canal.sv
// One unsigned counter channel with sticky overflow and wrap/saturate mode.
// Latency: value updates on the edge that samples enable.
// No backpressure: an increment is never refused, only wrapped or clamped.
module contador_canal
  import contador_pkg::*;
#(
  parameter int CONTADOR_LENGTH = 11
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       enable,
  input  logic                       modo_saturacion,
  output logic [CONTADOR_LENGTH-1:0] valor,
  output logic                       overflow
);

  localparam logic [CONTADOR_LENGTH-1:0] MAXIMO = '1;
  localparam logic [CONTADOR_LENGTH-1:0] UNO    = CONTADOR_LENGTH'(1);

  // Counter and sticky flag; clear wins over an increment on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      valor    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      valor    <= '0;
      overflow <= 1'b0;
    end else if (enable) begin
      if (valor == MAXIMO) begin
        overflow <= 1'b1;
        valor    <= modo_saturacion ? MAXIMO : '0;
      end else begin
        valor <= valor + UNO;
      end
    end
  end

endmodule

// File: rtl/contador_ciclos_multicanal.sv
// Multi-channel performance counter: ch0 counts RUN cycles, ch1.. count event strobes; snapshot bank for readout.
// Latency: o_cuenta follows i_sel by one cycle; o_valid rises the edge after a snapshot. Optional CONTADOR_COMPARE_EN adds a cycle-budget compare.
// No backpressure: strobes are counted every cycle in RUN; snapshots may be requested back to back.
module contador_ciclos_multicanal
  import contador_pkg::*;
#(
  parameter int CONTADOR_LENGTH = 11,
  parameter int NB_CANALES      = 4,
  parameter int NB_SEL          = 2
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic                       i_halt,
  input  logic                       i_clear,
  input  logic [NB_CANALES-1:0]      i_event,
  input  logic                       i_modo_saturacion,
  input  logic                       i_snapshot,
  input  logic [NB_SEL-1:0]          i_sel,
  output logic [CONTADOR_LENGTH-1:0] o_cuenta,
  output logic [NB_CANALES-1:0]      o_overflow,
  output logic [NB_ESTADO-1:0]       o_estado,
  output logic                       o_valid
`ifdef CONTADOR_COMPARE_EN
  ,
  input  logic [CONTADOR_LENGTH-1:0] i_umbral,
  output logic                       o_match
`endif
);

  localparam int NB_ENTRADAS = 2 ** NB_SEL;

  logic [NB_ESTADO-1:0]       estado;
  logic                       en_cuenta;
  logic [NB_CANALES-1:0]      incremento;
  logic [CONTADOR_LENGTH-1:0] valor      [NB_CANALES];
  logic [CONTADOR_LENGTH-1:0] sombra     [NB_CANALES];
  logic [CONTADOR_LENGTH-1:0] sombra_ext [NB_ENTRADAS];
  logic                       captura_d;
  logic                       limite;

  // Bit 0 of the strobe vector has no channel: ch0 counts cycles instead.
  logic unused_evento0;
  assign unused_evento0 = i_event[0];

  // Counting happens only on edges where the registered state is RUN.
  assign en_cuenta  = (estado == ESTADO_RUN);
  assign incremento = {i_event[NB_CANALES-1:1], 1'b1} & {NB_CANALES{en_cuenta}};
  assign o_estado   = estado;

  genvar k;
  generate
    for (k = 0; k < NB_CANALES; k++) begin : g_canal
      contador_canal #(
        .CONTADOR_LENGTH (CONTADOR_LENGTH)
      ) u_canal (
        .clock           (i_clock),
        .reset           (i_reset),
        .clear           (i_clear),
        .enable          (incremento[k]),
        .modo_saturacion (i_modo_saturacion),
        .valor           (valor[k]),
        .overflow        (o_overflow[k])
      );
    end
  endgenerate

`ifdef CONTADOR_COMPARE_EN
  localparam logic [CONTADOR_LENGTH-1:0] MAXIMO = '1;
  localparam logic [CONTADOR_LENGTH-1:0] UNO    = CONTADOR_LENGTH'(1);

  logic [CONTADOR_LENGTH-1:0] siguiente0;

  // Value ch0 will take on this edge, so the budget edge is detected before it lands.
  always_comb begin
    siguiente0 = valor[0] + UNO;
    if (valor[0] == MAXIMO) begin
      siguiente0 = i_modo_saturacion ? MAXIMO : '0;
    end
    limite = en_cuenta && (siguiente0 != valor[0]) && (siguiente0 == i_umbral);
  end

  // One-cycle pulse on the edge that brings ch0 onto the threshold.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_match <= 1'b0;
    end else if (i_clear) begin
      o_match <= 1'b0;
    end else begin
      o_match <= limite;
    end
  end
`else
  assign limite = 1'b0;
`endif

  // Run/halt FSM; clear returns to IDLE from anywhere, HALTED only leaves via clear.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      estado <= ESTADO_IDLE;
    end else if (i_clear) begin
      estado <= ESTADO_IDLE;
    end else begin
      case (estado)
        ESTADO_IDLE: begin
          if (i_start) estado <= ESTADO_RUN;
        end
        ESTADO_RUN: begin
          if (i_halt || limite) estado <= ESTADO_HALTED;
        end
        ESTADO_HALTED: begin
          estado <= ESTADO_HALTED;
        end
        default: begin
          estado <= ESTADO_IDLE;
        end
      endcase
    end
  end

  // Shadow bank takes the pre-increment (and pre-clear) live values.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int c = 0; c < NB_CANALES; c++) sombra[c] <= '0;
      captura_d <= 1'b0;
      o_valid   <= 1'b0;
    end else begin
      if (i_snapshot) begin
        for (int c = 0; c < NB_CANALES; c++) sombra[c] <= valor[c];
      end
      captura_d <= i_snapshot;
      o_valid   <= captura_d;
    end
  end

  // Pad the bank to the full selector range so unused codes read zero.
  always_comb begin
    for (int e = 0; e < NB_ENTRADAS; e++) sombra_ext[e] = '0;
    for (int c = 0; c < NB_CANALES; c++)  sombra_ext[c] = sombra[c];
  end

  // Registered readout mux.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_cuenta <= '0;
    end else begin
      o_cuenta <= sombra_ext[i_sel];
    end
  end

endmodule

// File: tb/tb_contador_ciclos_multicanal.sv
module tb_contador_ciclos_multicanal;

  localparam int L    = 11;
  localparam int NB   = 4;
  localparam int NS   = 2;
  localparam int MAXV = (1 << L) - 1;

  logic          clk = 1'b0;
  logic          i_reset, i_start, i_halt, i_clear, i_modo_saturacion, i_snapshot;
  logic [NB-1:0] i_event;
  logic [NS-1:0] i_sel;
  logic [L-1:0]  o_cuenta;
  logic [NB-1:0] o_overflow;
  logic [1:0]    o_estado;
  logic          o_valid;
`ifdef CONTADOR_COMPARE_EN
  logic [L-1:0]  i_umbral;
  logic          o_match;
`endif

  always #5 clk = ~clk;

  contador_ciclos_multicanal #(
    .CONTADOR_LENGTH (L),
    .NB_CANALES      (NB),
    .NB_SEL          (NS)
  ) dut (
    .i_clock           (clk),
    .i_reset           (i_reset),
    .i_start           (i_start),
    .i_halt            (i_halt),
    .i_clear           (i_clear),
    .i_event           (i_event),
    .i_modo_saturacion (i_modo_saturacion),
    .i_snapshot        (i_snapshot),
    .i_sel             (i_sel),
    .o_cuenta          (o_cuenta),
    .o_overflow        (o_overflow),
    .o_estado          (o_estado),
    .o_valid           (o_valid)
`ifdef CONTADOR_COMPARE_EN
    ,
    .i_umbral          (i_umbral),
    .o_match           (o_match)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: 0 = IDLE, 1 = RUN, 2 = HALTED; counts kept as plain integers.
  int m_cnt    [NB];
  int m_shadow [NB];
  bit m_ov     [NB];
  int m_state;
  int m_cuenta;
  bit m_valid;
  bit m_snapd;
  bit m_match;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ov_bits();
    int r = 0;
    for (int k = 0; k < NB; k++) if (m_ov[k]) r |= (1 << k);
    return r;
  endfunction

  task automatic model_update();
    bit hit = 1'b0;
    int nxt0;
    if (i_reset) begin
      for (int k = 0; k < NB; k++) begin
        m_cnt[k] = 0; m_shadow[k] = 0; m_ov[k] = 1'b0;
      end
      m_state = 0; m_cuenta = 0; m_valid = 1'b0; m_snapd = 1'b0; m_match = 1'b0;
    end else begin
      m_cuenta = (int'(i_sel) < NB) ? m_shadow[int'(i_sel)] : 0;
      m_valid  = m_snapd;
      m_snapd  = i_snapshot;
      if (i_snapshot) for (int k = 0; k < NB; k++) m_shadow[k] = m_cnt[k];
      m_match = 1'b0;
      if (i_clear) begin
        for (int k = 0; k < NB; k++) begin
          m_cnt[k] = 0; m_ov[k] = 1'b0;
        end
        m_state = 0;
      end else if (m_state == 1) begin
        nxt0 = (m_cnt[0] == MAXV) ? (i_modo_saturacion ? MAXV : 0) : m_cnt[0] + 1;
`ifdef CONTADOR_COMPARE_EN
        hit = (nxt0 != m_cnt[0]) && (nxt0 == int'(i_umbral));
`endif
        for (int k = 0; k < NB; k++) begin
          if (k == 0 || i_event[k]) begin
            if (m_cnt[k] == MAXV) begin
              m_ov[k] = 1'b1;
              if (!i_modo_saturacion) m_cnt[k] = 0;
            end else begin
              m_cnt[k] = m_cnt[k] + 1;
            end
          end
        end
        if (i_halt || hit) m_state = 2;
        m_match = hit;
      end else if (m_state == 0 && i_start) begin
        m_state = 1;
      end
    end
  endtask

  // One clock: update model with the inputs in force, check all outputs, drop pulses.
  task automatic ciclo();
    model_update();
    @(posedge clk);
    #1;
    check("estado",   32'(o_estado),   32'(m_state));
    check("overflow", 32'(o_overflow), 32'(ov_bits()));
    check("cuenta",   32'(o_cuenta),   32'(m_cuenta));
    check("valid",    32'(o_valid),    32'(m_valid));
`ifdef CONTADOR_COMPARE_EN
    check("match",    32'(o_match),    32'(m_match));
`endif
    i_reset = 1'b0; i_start = 1'b0; i_halt = 1'b0; i_clear = 1'b0;
    i_snapshot = 1'b0; i_event = '0;
  endtask

  task automatic correr(input int n, input logic [NB-1:0] mask);
    for (int i = 0; i < n; i++) begin
      i_event = NB'($urandom) & mask;
      ciclo();
    end
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_halt = 1'b0; i_clear = 1'b0;
    i_snapshot = 1'b0; i_event = '0; i_modo_saturacion = 1'b0; i_sel = '0;
`ifdef CONTADOR_COMPARE_EN
    i_umbral = '0;
`endif
    ciclo();
    check("rst_cuenta", 32'(o_cuenta), 32'd0);
    check("rst_estado", 32'(o_estado), 32'd0);

    // 100 RUN cycles then halt: ch0 sees 101 increments.
    i_start = 1'b1; ciclo();
    correr(100, 4'b1110);
    i_halt = 1'b1; ciclo();
    check("halted", 32'(o_estado), 32'd2);
    i_snapshot = 1'b1; i_sel = 0; ciclo();
    check("valid_not_yet", 32'(o_valid), 32'd0);
    ciclo();
    check("ch0_101", 32'(o_cuenta), 32'd101);
    check("valid_pulse", 32'(o_valid), 32'd1);
    ciclo();
    check("valid_drop", 32'(o_valid), 32'd0);
    i_start = 1'b1; ciclo();
    check("halted_ignores_start", 32'(o_estado), 32'd2);
    for (int s = 1; s < NB; s++) begin
      i_sel = NS'(s); ciclo();
    end

    // Saturating run of 2050 cycles.
    i_clear = 1'b1; i_modo_saturacion = 1'b1; ciclo();
    check("clear_idle", 32'(o_estado), 32'd0);
    i_start = 1'b1; ciclo();
    correr(2049, 4'b0000);
    i_halt = 1'b1; ciclo();
    i_snapshot = 1'b1; i_sel = 0; ciclo();
    ciclo();
    check("sat_2047", 32'(o_cuenta), 32'd2047);
    check("sat_ovf", 32'(o_overflow), 32'd1);

    // Same run wrapping.
    i_clear = 1'b1; i_modo_saturacion = 1'b0; ciclo();
    check("clear_ovf", 32'(o_overflow), 32'd0);
    i_start = 1'b1; ciclo();
    correr(2049, 4'b0000);
    i_halt = 1'b1; ciclo();
    i_snapshot = 1'b1; ciclo();
    ciclo();
`ifndef CONTADOR_COMPARE_EN
    check("wrap_2", 32'(o_cuenta), 32'd2);
    check("wrap_ovf0", 32'(o_overflow[0]), 32'd1);
`endif

    // Event strobes on ch2 for 37 cycles, bit 0 always high.
    i_clear = 1'b1; ciclo();
    i_start = 1'b1; ciclo();
    for (int i = 0; i < 60; i++) begin
      i_event = (i < 37) ? 4'b0101 : 4'b0001;
      ciclo();
    end
    i_event = 4'b0001; i_halt = 1'b1; ciclo();
    i_snapshot = 1'b1; i_sel = 0; ciclo();
    ciclo();
    check("ev_ch0", 32'(o_cuenta), 32'd61);
    i_sel = 1; ciclo();
    check("ev_ch1", 32'(o_cuenta), 32'd0);
    i_sel = 2; ciclo();
    check("ev_ch2", 32'(o_cuenta), 32'd37);
    i_sel = 3; ciclo();
    check("ev_ch3", 32'(o_cuenta), 32'd0);

    // Snapshot on the same edge as the 500 -> 501 increment.
    i_clear = 1'b1; ciclo();
    i_start = 1'b1; ciclo();
    correr(500, 4'b1000);
    i_snapshot = 1'b1; i_halt = 1'b1; i_sel = 0; ciclo();
    ciclo();
    check("snap_pre_500", 32'(o_cuenta), 32'd500);
    i_snapshot = 1'b1; ciclo();
    ciclo();
    check("live_501", 32'(o_cuenta), 32'd501);
    i_sel = 3; ciclo();
    check("sel3", 32'(o_cuenta), 32'(m_shadow[3]));

    // Snapshot together with clear keeps pre-clear values.
    i_snapshot = 1'b1; i_clear = 1'b1; i_sel = 0; ciclo();
    ciclo();
    check("snap_clear", 32'(o_cuenta), 32'd501);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      i_reset    = ($urandom_range(0, 99) == 0);
      i_clear    = ($urandom_range(0, 39) == 0);
      i_start    = ($urandom_range(0, 7) == 0);
      i_halt     = ($urandom_range(0, 29) == 0);
      i_snapshot = ($urandom_range(0, 5) == 0);
      i_event    = NB'($urandom);
      i_sel      = NS'($urandom);
      if ($urandom_range(0, 29) == 0) i_modo_saturacion = ~i_modo_saturacion;
      ciclo();
    end

    // Reset in the middle of a run.
    i_clear = 1'b1; ciclo();
    i_start = 1'b1; ciclo();
    correr(20, 4'b1110);
    i_snapshot = 1'b1; i_sel = 0; ciclo();
    ciclo();
    check("pre_reset_nonzero", 32'(o_cuenta != 0), 32'd1);
    i_reset = 1'b1; i_snapshot = 1'b1; i_event = 4'b1111; ciclo();
    check("rst_run_cuenta", 32'(o_cuenta), 32'd0);
    check("rst_run_ovf", 32'(o_overflow), 32'd0);
    check("rst_run_valid", 32'(o_valid), 32'd0);
    check("rst_run_estado", 32'(o_estado), 32'd0);
    i_halt = 1'b1; ciclo();
    check("halt_in_idle", 32'(o_estado), 32'd0);
    i_start = 1'b1; i_halt = 1'b1; ciclo();
    check("start_halt_idle", 32'(o_estado), 32'd1);

`ifdef CONTADOR_COMPARE_EN
    i_clear = 1'b1; i_umbral = 11'd20; ciclo();
    i_start = 1'b1; ciclo();
    correr(19, 4'b0000);
    check("cmp_before", 32'(o_match), 32'd0);
    ciclo();
    check("cmp_match", 32'(o_match), 32'd1);
    check("cmp_halted", 32'(o_estado), 32'd2);
    ciclo();
    check("cmp_pulse", 32'(o_match), 32'd0);
    i_snapshot = 1'b1; i_sel = 0; ciclo();
    ciclo();
    check("cmp_hold20", 32'(o_cuenta), 32'd20);
    i_clear = 1'b1; ciclo();
    check("cmp_clear_idle", 32'(o_estado), 32'd0);
    i_snapshot = 1'b1; ciclo();
    ciclo();
    check("cmp_clear_zero", 32'(o_cuenta), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
